alu_arbiter: RTL and testbench

Shares one FP ALU instance (op_a/op_b/op_code/mode_fp/round_mode/start → result/valid_out/flags handshake) among NUM_REQ requesters. Arbitration is round-robin. The block latches the winning request, holds start until valid_out, returns result and flags to the owner, and recovers from a hung ALU by timeout. It sits between the front-end controllers (switch/FSM front end, future UART front end) and the alu instance.

---
 rtl/fp_alu_pkg.sv | 31 +++
 rtl/alu_arbiter_rr_pick.sv | 41 ++++
 rtl/alu_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_alu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fp_alu_pkg
// Brief    : Shared widths, ALU op codes and arbiter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package fp_alu_pkg;

    localparam int WORD_W  = 32;
    localparam int HALF_W  = 16;
    localparam int FLAGS_W = 5;
    localparam int OPC_W   = 3;

    localparam logic [OPC_W-1:0] OP_ADD = 3'd0;
    localparam logic [OPC_W-1:0] OP_SUB = 3'd1;
    localparam logic [OPC_W-1:0] OP_MUL = 3'd2;
    localparam logic [OPC_W-1:0] OP_DIV = 3'd3;

    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;

    // Half-precision operands live in the low half; the upper half is cleared.
    function automatic logic [WORD_W-1:0] mask_operand(input logic [WORD_W-1:0] op,
                                                       input logic              mode_fp);
        return mode_fp ? op : {{(WORD_W-HALF_W){1'b0}}, op[HALF_W-1:0]};
    endfunction

endpackage : fp_alu_pkg
`default_nettype wire

// File: rtl/alu_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin pick: first set request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_winner_oh,
    output logic [IDX_W-1:0] o_winner_idx,
    output logic             o_any
);

    localparam logic [IDX_W:0] C_N = (IDX_W+1)'(N);

    logic [IDX_W:0] w_pos;

    always_comb begin
        o_winner_oh  = '0;
        o_winner_idx = '0;
        o_any        = 1'b0;
        w_pos        = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (w_pos >= C_N) begin
                w_pos = w_pos - C_N;
            end
            if (!o_any && i_req[w_pos[IDX_W-1:0]]) begin
                o_any                          = 1'b1;
                o_winner_idx                   = w_pos[IDX_W-1:0];
                o_winner_oh[w_pos[IDX_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one FP ALU among NUM_REQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import fp_alu_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [WORD_W*NUM_REQ-1:0] req_op_a,
    input  logic [WORD_W*NUM_REQ-1:0] req_op_b,
    input  logic [OPC_W*NUM_REQ-1:0]  req_op_code,
    input  logic [NUM_REQ-1:0]        req_mode_fp,
    input  logic [NUM_REQ-1:0]        req_round_mode,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [WORD_W-1:0]         rsp_result,
    output logic [FLAGS_W-1:0]        rsp_flags,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic [WORD_W-1:0]         alu_op_a,
    output logic [WORD_W-1:0]         alu_op_b,
    output logic [OPC_W-1:0]          alu_op_code,
    output logic                      alu_mode_fp,
    output logic                      alu_round_mode,
    output logic                      alu_start,
    input  logic [WORD_W-1:0]         alu_result,
    input  logic                      alu_valid_out,
    input  logic [FLAGS_W-1:0]        alu_flags
);

    localparam int C_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(NUM_REQ - 1);

    logic [WORD_W-1:0] w_slice_a  [NUM_REQ];
    logic [WORD_W-1:0] w_slice_b  [NUM_REQ];
    logic [OPC_W-1:0]  w_slice_op [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign w_slice_a[gi]  = req_op_a[gi*WORD_W +: WORD_W];
        assign w_slice_b[gi]  = req_op_b[gi*WORD_W +: WORD_W];
        assign w_slice_op[gi] = req_op_code[gi*OPC_W +: OPC_W];
    end

    logic [ST_W-1:0]    r_state_q,      w_state_d;
    logic [C_IDX_W-1:0] r_ptr_q,        w_ptr_d;
    logic [C_IDX_W-1:0] r_owner_q,      w_owner_d;
    logic [C_CNT_W-1:0] r_cnt_q,        w_cnt_d;
    logic [NUM_REQ-1:0] r_gnt_q,        w_gnt_d;
    logic [NUM_REQ-1:0] r_done_q,       w_done_d;
    logic [WORD_W-1:0]  r_rsp_result_q, w_rsp_result_d;
    logic [FLAGS_W-1:0] r_rsp_flags_q,  w_rsp_flags_d;
    logic               r_rsp_tmo_q,    w_rsp_tmo_d;
    logic               r_busy_q,       w_busy_d;
    logic [WORD_W-1:0]  r_alu_a_q,      w_alu_a_d;
    logic [WORD_W-1:0]  r_alu_b_q,      w_alu_b_d;
    logic [OPC_W-1:0]   r_alu_op_q,     w_alu_op_d;
    logic               r_alu_fp_q,     w_alu_fp_d;
    logic               r_alu_rm_q,     w_alu_rm_d;
    logic               r_alu_start_q,  w_alu_start_d;

    logic [NUM_REQ-1:0] w_win_oh;
    logic [C_IDX_W-1:0] w_win_idx;
    logic               w_any;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (C_IDX_W)
    ) u_rr_pick (
        .i_req        (req),
        .i_ptr        (r_ptr_q),
        .o_winner_oh  (w_win_oh),
        .o_winner_idx (w_win_idx),
        .o_any        (w_any)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_ptr_d        = r_ptr_q;
        w_owner_d      = r_owner_q;
        w_cnt_d        = r_cnt_q;
        w_gnt_d        = '0;
        w_done_d       = '0;
        w_rsp_result_d = r_rsp_result_q;
        w_rsp_flags_d  = r_rsp_flags_q;
        w_rsp_tmo_d    = r_rsp_tmo_q;
        w_alu_a_d      = r_alu_a_q;
        w_alu_b_d      = r_alu_b_q;
        w_alu_op_d     = r_alu_op_q;
        w_alu_fp_d     = r_alu_fp_q;
        w_alu_rm_d     = r_alu_rm_q;
        w_alu_start_d  = r_alu_start_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_any) begin
                    w_gnt_d       = w_win_oh;
                    w_owner_d     = w_win_idx;
                    w_ptr_d       = (w_win_idx == C_IDX_LAST) ? '0 : w_win_idx + C_IDX_W'(1);
                    w_cnt_d       = '0;
                    w_alu_a_d     = mask_operand(w_slice_a[w_win_idx], req_mode_fp[w_win_idx]);
                    w_alu_b_d     = mask_operand(w_slice_b[w_win_idx], req_mode_fp[w_win_idx]);
                    w_alu_op_d    = w_slice_op[w_win_idx];
                    w_alu_fp_d    = req_mode_fp[w_win_idx];
                    w_alu_rm_d    = req_round_mode[w_win_idx];
                    w_alu_start_d = 1'b1;
                    w_state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cnt_d = r_cnt_q + C_CNT_W'(1);
                // A real result beats an expiry landing on the same cycle.
                if (alu_valid_out) begin
                    w_rsp_result_d       = alu_result;
                    w_rsp_flags_d        = alu_flags;
                    w_rsp_tmo_d          = 1'b0;
                    w_done_d[r_owner_q]  = 1'b1;
                    w_alu_start_d        = 1'b0;
                    w_state_d            = ST_DRAIN;
                end else if (r_cnt_q == C_CNT_LAST) begin
                    w_rsp_result_d       = '0;
                    w_rsp_flags_d        = '0;
                    w_rsp_tmo_d          = 1'b1;
                    w_done_d[r_owner_q]  = 1'b1;
                    w_alu_start_d        = 1'b0;
                    w_state_d            = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!alu_valid_out) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_alu_start_d = 1'b0;
                w_state_d     = ST_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_ptr_q        <= '0;
            r_owner_q      <= '0;
            r_cnt_q        <= '0;
            r_gnt_q        <= '0;
            r_done_q       <= '0;
            r_rsp_result_q <= '0;
            r_rsp_flags_q  <= '0;
            r_rsp_tmo_q    <= 1'b0;
            r_busy_q       <= 1'b0;
            r_alu_a_q      <= '0;
            r_alu_b_q      <= '0;
            r_alu_op_q     <= '0;
            r_alu_fp_q     <= 1'b0;
            r_alu_rm_q     <= 1'b0;
            r_alu_start_q  <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_ptr_q        <= w_ptr_d;
            r_owner_q      <= w_owner_d;
            r_cnt_q        <= w_cnt_d;
            r_gnt_q        <= w_gnt_d;
            r_done_q       <= w_done_d;
            r_rsp_result_q <= w_rsp_result_d;
            r_rsp_flags_q  <= w_rsp_flags_d;
            r_rsp_tmo_q    <= w_rsp_tmo_d;
            r_busy_q       <= w_busy_d;
            r_alu_a_q      <= w_alu_a_d;
            r_alu_b_q      <= w_alu_b_d;
            r_alu_op_q     <= w_alu_op_d;
            r_alu_fp_q     <= w_alu_fp_d;
            r_alu_rm_q     <= w_alu_rm_d;
            r_alu_start_q  <= w_alu_start_d;
        end
    end

    assign gnt            = r_gnt_q;
    assign done           = r_done_q;
    assign rsp_result     = r_rsp_result_q;
    assign rsp_flags      = r_rsp_flags_q;
    assign rsp_timeout    = r_rsp_tmo_q;
    assign busy           = r_busy_q;
    assign alu_op_a       = r_alu_a_q;
    assign alu_op_b       = r_alu_b_q;
    assign alu_op_code    = r_alu_op_q;
    assign alu_mode_fp    = r_alu_fp_q;
    assign alu_round_mode = r_alu_rm_q;
    assign alu_start      = r_alu_start_q;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed bench for alu_arbiter with a behavioural ALU responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    import fp_alu_pkg::*;

    localparam int N   = 3;
    localparam int TMO = 16;

    logic                  clk;
    logic                  rst;
    logic [N-1:0]          req;
    logic [WORD_W*N-1:0]   req_op_a;
    logic [WORD_W*N-1:0]   req_op_b;
    logic [OPC_W*N-1:0]    req_op_code;
    logic [N-1:0]          req_mode_fp;
    logic [N-1:0]          req_round_mode;
    logic [N-1:0]          gnt;
    logic [N-1:0]          done;
    logic [WORD_W-1:0]     rsp_result;
    logic [FLAGS_W-1:0]    rsp_flags;
    logic                  rsp_timeout;
    logic                  busy;
    logic [WORD_W-1:0]     alu_op_a;
    logic [WORD_W-1:0]     alu_op_b;
    logic [OPC_W-1:0]      alu_op_code;
    logic                  alu_mode_fp;
    logic                  alu_round_mode;
    logic                  alu_start;
    logic [WORD_W-1:0]     alu_result;
    logic                  alu_valid_out;
    logic [FLAGS_W-1:0]    alu_flags;

    alu_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_op_a       (req_op_a),
        .req_op_b       (req_op_b),
        .req_op_code    (req_op_code),
        .req_mode_fp    (req_mode_fp),
        .req_round_mode (req_round_mode),
        .gnt            (gnt),
        .done           (done),
        .rsp_result     (rsp_result),
        .rsp_flags      (rsp_flags),
        .rsp_timeout    (rsp_timeout),
        .busy           (busy),
        .alu_op_a       (alu_op_a),
        .alu_op_b       (alu_op_b),
        .alu_op_code    (alu_op_code),
        .alu_mode_fp    (alu_mode_fp),
        .alu_round_mode (alu_round_mode),
        .alu_start      (alu_start),
        .alu_result     (alu_result),
        .alu_valid_out  (alu_valid_out),
        .alu_flags      (alu_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: valid after m_latency start-high cycles, held m_hold_len cycles.
    int m_latency;
    int m_hold_len;
    bit m_respond;
    int m_cnt;
    int m_hold;
    bit m_served;

    function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                                 input logic [2:0] opc, input logic fp);
        if (opc == OP_ADD && fp && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt         <= 0;
            m_hold        <= 0;
            m_served      <= 1'b0;
            alu_valid_out <= 1'b0;
            alu_result    <= '0;
            alu_flags     <= '0;
        end else if (m_hold > 0) begin
            m_hold <= m_hold - 1;
            if (m_hold == 1) alu_valid_out <= 1'b0;
        end else if (alu_start && !m_served && m_respond) begin
            if (m_cnt >= m_latency - 1) begin
                alu_valid_out <= 1'b1;
                alu_result    <= model_result(alu_op_a, alu_op_b, alu_op_code, alu_mode_fp);
                alu_flags     <= {alu_op_code, alu_mode_fp, alu_round_mode};
                m_hold        <= m_hold_len;
                m_served      <= 1'b1;
                m_cnt         <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (!alu_start) begin
            m_served <= 1'b0;
            m_cnt    <= 0;
        end
    end

    int n_checks;
    int n_errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slice(input int who, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] opc, input logic fp, input logic rm);
        req_op_a[who*WORD_W +: WORD_W]  = a;
        req_op_b[who*WORD_W +: WORD_W]  = b;
        req_op_code[who*OPC_W +: OPC_W] = opc;
        req_mode_fp[who]                = fp;
        req_round_mode[who]             = rm;
    endtask

    task automatic wait_done(output logic [N-1:0] d, output int cycles, output int gnts);
        d      = '0;
        cycles = 0;
        gnts   = 0;
        while (cycles < 200) begin
            tick();
            cycles++;
            if (gnt != '0) gnts++;
            if (done != '0) begin
                d = done;
                return;
            end
        end
    endtask

    task automatic wait_gnt(output logic [N-1:0] g, output int cycles);
        g      = '0;
        cycles = 0;
        while (cycles < 200) begin
            tick();
            cycles++;
            if (gnt != '0) begin
                g = gnt;
                return;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy; i++) tick();
        check("busy_clear", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt_done"}, 64'({gnt, done}), 64'd0);
        check({tag, "_rsp_busy"}, 64'({rsp_result, rsp_flags, rsp_timeout, busy}), 64'd0);
        check({tag, "_alu_ops"},  64'({alu_op_a, alu_op_b}), 64'd0);
        check({tag, "_alu_cfg"},  64'({alu_op_code, alu_mode_fp, alu_round_mode, alu_start}), 64'd0);
    endtask

    task automatic single_op(input int who, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] opc, input logic fp, input logic rm,
                             input logic [31:0] exp_a, input logic [31:0] exp_b,
                             input logic [31:0] exp_res, input logic [4:0] exp_flags);
        logic [N-1:0] d;
        int           cyc;
        int           g;
        set_slice(who, a, b, opc, fp, rm);
        req      = '0;
        req[who] = 1'b1;
        tick();
        check("gnt",           64'(gnt),         64'(1) << who);
        check("start_latency", 64'(alu_start),   64'd1);
        check("alu_op_a",      64'(alu_op_a),    64'(exp_a));
        check("alu_op_b",      64'(alu_op_b),    64'(exp_b));
        check("alu_cfg",       64'({alu_op_code, alu_mode_fp, alu_round_mode}), 64'({opc, fp, rm}));
        req = '0;
        wait_done(d, cyc, g);
        check("done",          64'(d),           64'(1) << who);
        check("gnt_while_busy", 64'(g),          64'd0);
        check("rsp_result",    64'(rsp_result),  64'(exp_res));
        check("rsp_flags",     64'(rsp_flags),   64'(exp_flags));
        check("rsp_timeout",   64'(rsp_timeout), 64'd0);
        wait_idle();
    endtask

    typedef struct {
        int          who;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  opc;
        logic        fp;
        logic        rm;
        int          lat;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_res;
        logic [4:0]  exp_flags;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [N-1:0] d;
        logic [N-1:0] g;
        int           cyc;
        int           gcount;
        int           n_start;
        int           n_low;
        int           n_done;

        vecs[0] = '{0, 32'h3F80_0000, 32'h4000_0000, 3'd0, 1'b1, 1'b0, 5,
                    32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'b00010};
        vecs[1] = '{1, 32'hDEAD_BEEF, 32'h1234_5678, 3'd2, 1'b0, 1'b1, 2,
                    32'h0000_BEEF, 32'h0000_5678, 32'h0001_1567, 5'b01001};
        vecs[2] = '{2, 32'h0000_0010, 32'h0000_0020, 3'd1, 1'b1, 1'b1, 1,
                    32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 5'b00111};
        vecs[3] = '{0, 32'hFFFF_0001, 32'h0000_0001, 3'd3, 1'b0, 1'b0, 3,
                    32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 5'b01100};
        vecs[4] = '{2, 32'h8000_0000, 32'h8000_0000, 3'd4, 1'b1, 1'b0, 1,
                    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 5'b10010};

        n_checks       = 0;
        n_errors       = 0;
        m_latency      = 1;
        m_hold_len     = 1;
        m_respond      = 1'b1;
        rst            = 1'b1;
        req            = '0;
        req_op_a       = '0;
        req_op_b       = '0;
        req_op_code    = '0;
        req_mode_fp    = '0;
        req_round_mode = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            m_latency = vecs[i].lat;
            single_op(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].opc, vecs[i].fp, vecs[i].rm,
                      vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_res, vecs[i].exp_flags);
        end

        // Simultaneous requests 0 and 1; pointer is back at 0 after requester 2 won last.
        m_latency = 2;
        set_slice(0, 32'h0000_0100, 32'h0000_0001, 3'd0, 1'b1, 1'b0);
        set_slice(1, 32'h0000_0200, 32'h0000_0002, 3'd1, 1'b1, 1'b0);
        req = 3'b011;
        tick();
        check("sim_gnt0", 64'(gnt), 64'd1);
        req[0] = 1'b0;
        wait_done(d, cyc, gcount);
        check("sim_done0",    64'(d),          64'd1);
        check("sim_no_regnt", 64'(gcount),     64'd0);
        check("sim_result0",  64'(rsp_result), 64'h101);
        check("sim_flags0",   64'(rsp_flags),  64'b00010);
        wait_gnt(g, cyc);
        check("sim_gnt1", 64'(g), 64'd2);
        req[1] = 1'b0;
        wait_done(d, cyc, gcount);
        check("sim_done1",   64'(d),          64'd2);
        check("sim_result1", 64'(rsp_result), 64'h202);
        check("sim_flags1",  64'(rsp_flags),  64'b00110);
        wait_idle();

        // Reset brings the pointer back to 0, then three held requests rotate fairly.
        rst = 1'b1;
        tick();
        check_reset_outputs("reset2");
        rst       = 1'b0;
        m_latency = 1;
        for (int i = 0; i < N; i++) set_slice(i, 32'(i + 1), 32'h10, 3'd0, 1'b1, 1'b0);
        req = 3'b111;
        for (int k = 0; k < 9; k++) begin
            wait_gnt(g, cyc);
            check("rr_gnt", 64'(g), 64'(1) << (k % 3));
            wait_done(d, cyc, gcount);
            check("rr_done",   64'(d),          64'(1) << (k % 3));
            check("rr_result", 64'(rsp_result), 64'(32'h11 + 32'(k % 3)));
        end
        req = '0;
        wait_idle();

        // Silent ALU: ISSUE must last exactly TMO cycles, then a timeout response.
        m_respond = 1'b0;
        set_slice(1, 32'h5, 32'h6, 3'd0, 1'b1, 1'b0);
        req = 3'b010;
        tick();
        check("tmo_gnt", 64'(gnt), 64'd2);
        req     = '0;
        n_start = 1;
        n_low   = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done != '0) break;
            n_start++;
            if (!alu_start) n_low++;
        end
        check("tmo_start_cycles", 64'(n_start),     64'(TMO));
        check("tmo_start_held",   64'(n_low),       64'd0);
        check("tmo_done",         64'(done),        64'd2);
        check("tmo_flag",         64'(rsp_timeout), 64'd1);
        check("tmo_result",       64'({rsp_result, rsp_flags}), 64'd0);
        check("tmo_start_drop",   64'(alu_start),   64'd0);
        m_respond = 1'b1;
        wait_idle();
        single_op(1, 32'h0000_0003, 32'h0000_0004, 3'd1, 1'b1, 1'b1,
                  32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 5'b00111);

        // Lingering valid_out: pending request must wait until valid drops.
        m_hold_len = 5;
        set_slice(0, 32'h7, 32'h8, 3'd0, 1'b1, 1'b0);
        set_slice(2, 32'h9, 32'h1, 3'd0, 1'b1, 1'b0);
        req = 3'b001;
        tick();
        check("linger_gnt0", 64'(gnt), 64'd1);
        req = 3'b100;
        wait_done(d, cyc, gcount);
        check("linger_done0",   64'(d),          64'd1);
        check("linger_result0", 64'(rsp_result), 64'hF);
        m_hold_len = 1;
        wait_gnt(g, cyc);
        check("linger_gnt2",       64'(g),          64'd4);
        check("linger_regnt_wait", 64'(cyc),        64'd6);
        check("linger_rsp_hold",   64'(rsp_result), 64'hF);
        req = '0;
        wait_done(d, cyc, gcount);
        check("linger_done2",   64'(d),          64'd4);
        check("linger_result2", 64'(rsp_result), 64'hA);
        wait_idle();

        // Reset mid-ISSUE: everything clears on that edge and no done follows.
        m_respond = 1'b0;
        set_slice(1, 32'h11, 32'h22, 3'd2, 1'b1, 1'b1);
        req = 3'b010;
        tick();
        check("midrst_gnt", 64'(gnt), 64'd2);
        req = '0;
        tick();
        tick();
        check("midrst_issuing", 64'(alu_start), 64'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done != '0) n_done++;
        end
        check("midrst_no_done", 64'(n_done), 64'd0);
        check("midrst_idle",    64'({busy, alu_start}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_alu_arbiter
`default_nettype wire
